// File: rtl/z80_bus_pkg.sv
`default_nettype none
//==============================================================================
// Module : z80_bus_pkg
// Desc   : Shared types and constants for the z80 bus responder and monitor.
// Rev    : 1.0 - initial release
//==============================================================================
package z80_bus_pkg;

   typedef enum logic [2:0] {
      NONE    = 3'd0,
      MEM_RD  = 3'd1,
      MEM_WR  = 3'd2,
      IO_RD   = 3'd3,
      IO_WR   = 3'd4,
      FETCH   = 3'd5,
      INTA    = 3'd6,
      REFRESH = 3'd7
   } z80_bus_kind_t;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_RSP  = 2'd2,
      ST_HOLD = 2'd3
   } z80_bus_state_t;

   localparam logic [7:0] Z80_BUS_IDLE_DATA = 8'hFF;

   function automatic logic kind_is_write(input z80_bus_kind_t kind);
      return (kind == MEM_WR) || (kind == IO_WR);
   endfunction

   // INTA is an I/O-space cycle on the real part, so it takes the I/O wait budget
   function automatic logic kind_is_io(input z80_bus_kind_t kind);
      return (kind == IO_RD) || (kind == IO_WR) || (kind == INTA);
   endfunction

endpackage
`default_nettype wire

// File: rtl/z80_bus_decode.sv
`default_nettype none
//==============================================================================
// Module : z80_bus_decode
// Desc   : Combinational classifier turning z80 strobes into a bus cycle kind.
// Rev    : 1.0 - initial release
//==============================================================================
module z80_bus_decode
   import z80_bus_pkg::*;
(
   input  logic       nmreq,
   input  logic       niorq,
   input  logic       bus_nread,
   input  logic       bus_nwrite,
   input  logic       nm1,
   input  logic       nrfsh,
   output logic [2:0] kind
);

   // Priority order matters: refresh and M1 qualify the plain memory/IO decodes
   always_comb begin
      kind = NONE;
      if (!nrfsh)
         kind = REFRESH;
      else if (!nm1 && !niorq)
         kind = INTA;
      else if (!nm1 && !nmreq && !bus_nread)
         kind = FETCH;
      else if (!nmreq && !bus_nread)
         kind = MEM_RD;
      else if (!nmreq && !bus_nwrite)
         kind = MEM_WR;
      else if (!niorq && !bus_nread)
         kind = IO_RD;
      else if (!niorq && !bus_nwrite)
         kind = IO_WR;
   end

endmodule
`default_nettype wire

// File: rtl/z80_bus_responder.sv
`default_nettype none
//==============================================================================
// Module : z80_bus_responder
// Desc   : Turns z80 bus cycles into valid/ready store requests, stretching with nwait.
// Rev    : 1.0 - initial release
//==============================================================================
module z80_bus_responder
   import z80_bus_pkg::*;
#(
   parameter int MEM_WAIT = 0,
   parameter int IO_WAIT  = 1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [15:0] bus_addr,
   input  logic [7:0]  bus_wdata,
   input  logic        nmreq,
   input  logic        niorq,
   input  logic        bus_nread,
   input  logic        bus_nwrite,
   input  logic        nm1,
   input  logic        nrfsh,
   output logic [7:0]  bus_rdata,
   output logic        nwait,
   output logic        req_valid,
   input  logic        req_ready,
   output logic [2:0]  req_kind,
   output logic [15:0] req_addr,
   output logic [7:0]  req_wdata,
   input  logic        rsp_valid,
   input  logic [7:0]  rsp_rdata,
   output logic        protocol_err
);

   localparam logic [2:0] c_mem_wait = 3'(MEM_WAIT);
   localparam logic [2:0] c_io_wait  = 3'(IO_WAIT);

   z80_bus_state_t r_state;
   z80_bus_state_t w_state_next;
   z80_bus_kind_t  r_kind;
   z80_bus_kind_t  w_kind;
   logic [2:0]     w_kind_bits;
   logic [15:0]    r_addr;
   logic [7:0]     r_wdata;
   logic [7:0]     r_rdata;
   logic [2:0]     r_wait_cnt;
   logic           r_abort;
   logic           r_err;
   logic           w_strobes_idle;
   logic           w_start;

   z80_bus_decode u_decode (
      .nmreq      (nmreq),
      .niorq      (niorq),
      .bus_nread  (bus_nread),
      .bus_nwrite (bus_nwrite),
      .nm1        (nm1),
      .nrfsh      (nrfsh),
      .kind       (w_kind_bits)
   );

   assign w_kind         = z80_bus_kind_t'(w_kind_bits);
   assign w_strobes_idle = nmreq & niorq & bus_nread & bus_nwrite;
   assign w_start        = (w_kind != NONE) && (w_kind != REFRESH);

   always_ff @(posedge clk) begin
      if (reset)
         r_state <= ST_IDLE;
      else
         r_state <= w_state_next;
   end

   // An aborted cycle still completes its handshake with the store, then skips HOLD
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         ST_IDLE: if (w_start) w_state_next = ST_REQ;
         ST_REQ: begin
            if (req_ready) begin
               if (r_abort || w_strobes_idle)
                  w_state_next = ST_IDLE;
               else if (kind_is_write(r_kind))
                  w_state_next = ST_HOLD;
               else
                  w_state_next = ST_RSP;
            end
         end
         ST_RSP: begin
            if (rsp_valid)
               w_state_next = (r_abort || w_strobes_idle) ? ST_IDLE : ST_HOLD;
         end
         ST_HOLD: if (w_strobes_idle) w_state_next = ST_IDLE;
         default: w_state_next = ST_IDLE;
      endcase
   end

   always_comb begin
      req_valid = (r_state == ST_REQ);
      nwait     = !((r_state == ST_REQ) || (r_state == ST_RSP) || (r_wait_cnt != 3'd0));
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_kind     <= NONE;
         r_addr     <= 16'h0000;
         r_wdata    <= 8'h00;
         r_rdata    <= Z80_BUS_IDLE_DATA;
         r_wait_cnt <= 3'd0;
         r_abort    <= 1'b0;
         r_err      <= 1'b0;
      end else begin
         if (r_state == ST_IDLE && w_start) begin
            r_kind     <= w_kind;
            r_addr     <= bus_addr;
            r_wdata    <= bus_wdata;
            r_wait_cnt <= kind_is_io(w_kind) ? c_io_wait : c_mem_wait;
            r_abort    <= 1'b0;
         end else if (w_state_next == ST_IDLE) begin
            // nothing left to stretch once the cycle is gone
            r_wait_cnt <= 3'd0;
         end else if (r_wait_cnt != 3'd0) begin
            r_wait_cnt <= r_wait_cnt - 3'd1;
         end

         if ((r_state == ST_REQ || r_state == ST_RSP) && w_strobes_idle) begin
            r_abort <= 1'b1;
            r_err   <= 1'b1;
         end

         if (r_state == ST_RSP && rsp_valid && !r_abort && !w_strobes_idle)
            r_rdata <= rsp_rdata;
      end
   end

   assign bus_rdata    = r_rdata;
   assign req_kind     = r_kind;
   assign req_addr     = r_addr;
   assign req_wdata    = r_wdata;
   assign protocol_err = r_err;

endmodule
`default_nettype wire

// File: doc/z80_bus_responder.md
# z80_bus_responder

Bus-side responder for the z80 core's external pins: decodes memory, I/O, opcode-fetch and interrupt-acknowledge cycles from the core's strobes and forwards each one as a single valid/ready request to a backing store (RAM model, peripheral fabric). It stretches the cycle with `nwait` until the store answers, holds read data on `bus_rdata`, and ignores refresh cycles. It is instantiated beside the core in system builds and in the formal harness as the core's bus counterpart.

## Interface
Parameters:
- `MEM_WAIT`, 0: minimum wait states forced on every memory/fetch cycle (0–7).
- `IO_WAIT`, 1: minimum wait states forced on every I/O or interrupt-acknowledge cycle (0–7).

Ports:
- `clk`  in  1  single clock; all state changes on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `bus_addr`  in  16  core address bus.
- `bus_wdata`  in  8  core write data.
- `nmreq`, `niorq`, `bus_nread`, `bus_nwrite`, `nm1`, `nrfsh`  in  1 each  core strobes, active low.
- `bus_rdata`  out  8  read data to core READ_D.
- `nwait`  out  1  active-low wait to core nWAIT.
- `req_valid`  out  1  request to backing store.
- `req_ready`  in  1  store accepts request.
- `req_kind`  out  3  cycle kind (`z80_bus_kind_t`).
- `req_addr`  out  16  latched address.
- `req_wdata`  out  8  latched write data.
- `rsp_valid`  in  1  read response strobe (ignored for writes).
- `rsp_rdata`  in  8  read response data.
- `protocol_err`  out  1  sticky: core ended a cycle before it completed.

## Operation
- Classification, from sampled strobes, in priority order:
  - `nrfsh`=0: REFRESH, ignored.
  - `nm1`=0 & `niorq`=0: INTA.
  - `nm1`=0 & `nmreq`=0 & `bus_nread`=0: FETCH.
  - `nmreq`=0 & `bus_nread`=0: MEM_RD.
  - `nmreq`=0 & `bus_nwrite`=0: MEM_WR.
  - `niorq`=0 & `bus_nread`=0: IO_RD.
  - `niorq`=0 & `bus_nwrite`=0: IO_WR.
  - Otherwise: NONE. `nmreq` low without RD/WR is NONE until the data strobe arrives.
- FSM states IDLE, REQ, RSP, HOLD.
  - IDLE: on kind ≠ NONE/REFRESH, latch addr, wdata and kind; load wait counter with `MEM_WAIT` (mem/fetch) or `IO_WAIT` (io/inta); go to REQ.
  - REQ: `req_valid`=1. On `req_ready`, go to HOLD for writes or RSP for reads/fetch/INTA.
  - RSP: on `rsp_valid`, latch `rsp_rdata` into `bus_rdata` and go to HOLD.
  - HOLD: wait until all of `nmreq`, `niorq`, `bus_nread`, `bus_nwrite` are high, then go to IDLE. Back-to-back cycles need at least one sampled idle-strobe cycle between them.
- `nwait` is 0 in REQ and RSP, and also while the wait counter is nonzero. The counter decrements once per cycle outside IDLE and saturates at 0.
- Abort: if the strobes all deassert while in REQ or RSP, set `protocol_err`.
  - In REQ, `req_valid` is never retracted: stay until `req_ready`, discard the result, then return to IDLE.
  - In RSP, wait for `rsp_valid`, discard it, then return to IDLE.
- Reset values: FSM IDLE, `bus_rdata`=8'hFF, `nwait`=1, `req_valid`=0, `req_kind`=NONE, `req_addr`=0, `req_wdata`=0, `protocol_err`=0. Reset mid-cycle abandons any outstanding request without error.

## Timing
- All outputs are registered.
- Strobe first sampled at edge N: `req_valid`=1 and `nwait`=0 from N+1.
- `req_ready` at edge M: for writes, `nwait`=1 from M+1 (if the counter has expired).
- `rsp_valid` at edge R: `bus_rdata` valid and `nwait`=1 from R+1.
- Zero-latency store (`req_ready`=`rsp_valid`=1 always), read with `MEM_WAIT`=0: `nwait` low for exactly 2 cycles.
- `req_addr`/`req_wdata` are stable from REQ until the next IDLE exit.
- `rsp_valid` outside RSP is ignored. `req_ready` outside REQ is ignored.

## Structure
- Package `z80_bus_pkg`:
  - enum `z80_bus_kind_t`: NONE, MEM_RD, MEM_WR, IO_RD, IO_WR, FETCH, INTA, REFRESH.
  - FSM state enum.
  - Constant `Z80_BUS_IDLE_DATA`=8'hFF.
- Sub-module `z80_bus_decode`: combinational strobe classifier, reused by the bus monitor.

## Test plan
- MEM_RD at 16'h1234, store returns 8'hA5 two cycles after `req_ready` -> `req_kind`=MEM_RD; `nwait` low 4 cycles; `bus_rdata`=8'hA5 until strobes rise; one request only.
- IO_WR port 16'h00FE data 8'h3C, `IO_WAIT`=3, immediate `req_ready` -> `nwait` low ≥3 cycles; `req_wdata`=8'h3C; no `rsp_valid` needed.
- Refresh (`nrfsh`=0, `nmreq`=0, addr 16'h007F) -> `req_valid` never asserts; `nwait` stays 1.
- INTA (`nm1`=0, `niorq`=0), store returns 8'hFF -> `req_kind`=INTA; `bus_rdata`=8'hFF; `nwait` released one cycle after `rsp_valid`.
- Strobes drop while in REQ with `req_ready`=0 for 5 cycles -> `req_valid` held until ready; `protocol_err`=1; FSM returns to IDLE.
- `reset` asserted in RSP -> next cycle `nwait`=1, `req_valid`=0, `bus_rdata`=8'hFF, `protocol_err`=0.
